// File: rtl/disp_2de5_pkg.sv
// Shared types and tables for the 2-of-5 scanned display controller.
// Code weights 7-4-2-1-0 map to bits E1..E5 (bit 4 .. bit 0).
package disp_2de5_pkg;

    typedef enum logic {
        BLANK,
        DRIVE
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    localparam logic [4:0] CODE_TABLE [10] = '{
        5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
        5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100
    };

    // Segment order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    // Every 2-hot 5-bit pattern is a table entry, so a popcount of two is sufficient.
    function automatic logic is_valid_2de5(input logic [4:0] code);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < 5; i++) begin
            ones = ones + {31'b0, code[i]};
        end
        return ones == 2;
    endfunction

endpackage

// File: rtl/dec_2de5_7seg.sv
// Combinational 2-of-5 code to 7-segment decoder; unmatched codes give blank
// segments with valid low.
module dec_2de5_7seg
    import disp_2de5_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg,
    output logic       valid
);

    always_comb begin
        seg   = SEG_BLANK;
        valid = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (code == CODE_TABLE[i]) begin
                seg   = SEG_TABLE[i];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/disp_scan_2de5.sv
// Time-multiplexed 2-of-5 display scanner with frame-aligned double-buffered codes.
// Optional feature macro: DISP_ERR_BLINK_EN (blinking dash on invalid digits).
module disp_scan_2de5
    import disp_2de5_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLANK_CYC    = 50,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5*DIGITS-1:0]   code_in,
    input  logic                  upd_req,
    output logic                  upd_ack,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_start,
    output logic [DIGITS-1:0]     err
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = $clog2(DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    localparam bit PARAMS_OK = (DIGITS >= 2) && (DIGITS <= 8) && (SCAN_DIV >= 4) &&
                               (BLANK_CYC >= 1) && (BLANK_CYC < SCAN_DIV) &&
                               (BLINK_FRAMES >= 1);

    if (!PARAMS_OK) begin : g_bad_params
        $error("disp_scan_2de5: parameter combination out of range");
    end

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    scan_state_t           state_q, state_d;
    logic [5*DIGITS-1:0]   active_q, active_d;
    logic [5*DIGITS-1:0]   pending_q, pending_d;
    logic                  pend_v_q, pend_v_d;
    logic                  upd_ack_q, upd_ack_d;
    logic                  frame_start_q, frame_start_d;
    logic [DIGITS-1:0]     err_q, err_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     an_n_q, an_n_d;

    logic                  slot_end;
    logic                  frame_end;
    logic                  commit;
    logic [DIGITS-1:0]     pend_err;
    logic [4:0]            dec_code;
    logic [6:0]            dec_seg;
    logic                  dec_valid;
    logic [6:0]            invalid_seg;
    logic [6:0]            digit_seg;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);
    assign commit    = frame_end && pend_v_q;

    always_comb begin
        pend_err = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            pend_err[k] = (pending_q[5*k +: 5] != 5'b00000) &&
                          !is_valid_2de5(pending_q[5*k +: 5]);
        end
    end

    // A request on the commit cycle lands in pending after the old value moved
    // to active, so pend_v stays set for the following frame.
    always_comb begin
        cnt_d         = cnt_q + 1'b1;
        idx_d         = idx_q;
        active_d      = active_q;
        pending_d     = pending_q;
        pend_v_d      = pend_v_q;
        err_d         = err_q;
        upd_ack_d     = 1'b0;
        frame_start_d = frame_end;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = frame_end ? '0 : idx_q + 1'b1;
        end
        if (commit) begin
            active_d  = pending_q;
            pend_v_d  = 1'b0;
            upd_ack_d = 1'b1;
            err_d     = pend_err;
        end
        if (upd_req) begin
            pending_d = code_in;
            pend_v_d  = 1'b1;
        end
    end

    always_comb begin
        dec_code = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                dec_code = active_q[5*k +: 5];
            end
        end
    end

    dec_2de5_7seg u_dec (
        .code  (dec_code),
        .seg   (dec_seg),
        .valid (dec_valid)
    );

`ifdef DISP_ERR_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_start_q) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = !blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    always_comb begin
        invalid_seg = blink_phase_q ? SEG_BLANK : SEG_DASH;
    end
`else
    always_comb begin
        invalid_seg = SEG_BLANK;
    end
`endif

    always_comb begin
        if (dec_valid) begin
            digit_seg = dec_seg;
        end else if (dec_code == 5'b00000) begin
            digit_seg = SEG_BLANK;
        end else begin
            digit_seg = invalid_seg;
        end
    end

    // Scan FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // Scan FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BLANK: if (cnt_q == BLANK_LAST) state_d = DRIVE;
            DRIVE: if (slot_end)            state_d = BLANK;
            default:                        state_d = BLANK;
        endcase
    end

    // Scan FSM: outputs. Segments reload only during dead-time so a lit digit
    // never sees its pattern change.
    always_comb begin
        an_n_d = '1;
        seg_d  = seg_q;
        if (state_q == DRIVE) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    an_n_d[k] = 1'b0;
                end
            end
        end else begin
            seg_d = digit_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            active_q      <= '0;
            pending_q     <= '0;
            pend_v_q      <= 1'b0;
            upd_ack_q     <= 1'b0;
            frame_start_q <= 1'b0;
            err_q         <= '0;
            seg_q         <= SEG_BLANK;
            an_n_q        <= '1;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            pend_v_q      <= pend_v_d;
            upd_ack_q     <= upd_ack_d;
            frame_start_q <= frame_start_d;
            err_q         <= err_d;
            seg_q         <= seg_d;
            an_n_q        <= an_n_d;
        end
    end

    assign upd_ack     = upd_ack_q;
    assign frame_start = frame_start_q;
    assign err         = err_q;
    assign seg         = seg_q;
    assign an_n        = an_n_q;

endmodule

// File: doc/disp_scan_2de5.md
# disp_scan_2de5

Time-multiplexed display controller for the 2-of-5 readout. It shares one combinational 2-of-5 → 7-segment decoder among DIGITS common-anode digits. For each digit it sequences a blanking dead-time, then a drive interval. New codes are double-buffered and committed only at frame boundaries, so a digit never tears mid-frame. It sits between the code source (keyboard/counter logic) and the physical segment/anode pins.

## Interface
- DIGITS, 4: number of scanned digits (2..8).
- SCAN_DIV, 1000: clock cycles per digit slot (≥ 4).
- BLANK_CYC, 50: dead-time cycles at slot start; 1 ≤ BLANK_CYC < SCAN_DIV.
- BLINK_FRAMES, 64: frames per blink half-period (used only with ERR_BLINK_EN).
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- code_in  in  5*DIGITS  codes; digit k at [5k+4:5k], bit 5k+4 = E1 (weight 7) … bit 5k = E5 (weight 0).
- upd_req  in  1  one-cycle strobe: capture code_in into pending buffer.
- upd_ack  out  1  one-cycle pulse when pending codes become active.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- an_n  out  DIGITS  digit enables, active-low.
- frame_start  out  1  one-cycle pulse at start of digit-0 slot.
- err  out  DIGITS  per-digit invalid-code flag for the active frame.

## Operation
- Code table (7-4-2-1-0 weights E1..E5): 0=11000, 1=00011, 2=00101, 3=00110, 4=01001, 5=01010, 6=01100, 7=10001, 8=10010, 9=10100.
- 00000 = explicit blank: seg=0, err=0.
- Any other code without exactly two ones is invalid: err[k]=1, display per Configuration.
- Counters:
  - cnt runs 0..SCAN_DIV-1.
  - idx runs 0..DIGITS-1; it advances when cnt==SCAN_DIV-1 and wraps to 0.
- FSM:
  - BLANK while cnt<BLANK_CYC; DRIVE otherwise.
  - BLANK→DRIVE at cnt==BLANK_CYC.
  - DRIVE→BLANK at the slot wrap.
- Buffering:
  - upd_req copies code_in into pending and sets pend_v.
  - A later upd_req before commit overwrites pending (last wins; exactly one ack).
  - Commit happens on the cycle idx wraps to 0: active←pending, pend_v←0, upd_ack=1, err recomputed from new active codes.
  - upd_req on the commit cycle: the commit uses the old pending, the new value becomes the next pending, and pend_v stays 1.
  - upd_req with no pending and no commit gives no ack until the next frame.
- The decoder input is active[idx] only; all digits share one decoder instance.

## Timing
- Reset values: seg=0, an_n=all 1, upd_ack=0, frame_start=0, err=0, active=pending=all 00000, pend_v=0, cnt=0, idx=0, state=BLANK, blink phase=0.
- seg and an_n are registered, one cycle of latency after the state/cnt that produced them.
- an_n[idx]=0 exactly SCAN_DIV-BLANK_CYC cycles per slot; all bits are 1 for BLANK_CYC cycles.
- Only one an_n bit is ever low at a time.
- seg changes only while an_n is all 1.
- frame_start and upd_ack are registered, coincident, and asserted the cycle after the wrap into idx=0.
- Worst-case upd_req→upd_ack latency: DIGITS*SCAN_DIV+1 cycles.
- rst mid-frame returns everything to reset values on the next edge, discards pending, and blanks the display immediately.

## Configuration
- DISP_ERR_BLINK_EN defined:
  - Invalid digits show a dash (seg=1000000) that toggles on/off every BLINK_FRAMES frames.
  - The phase counter advances at frame_start.
- Undefined:
  - Invalid digits show seg=0.
  - No phase counter is built; BLINK_FRAMES is unused.
- err behaviour is identical in both cases.

## Structure
- Package disp_2de5_pkg:
  - CODE_TABLE (10×5 codes).
  - SEG_TABLE (10×7 patterns).
  - SEG_BLANK and SEG_DASH constants.
  - Scan state enum {BLANK, DRIVE}.
  - Function is_valid_2de5.
- Sub-module dec_2de5_7seg: combinational, 5-bit code → 7-bit seg plus valid.
- Scan counters, buffers and FSM stay in disp_scan_2de5.

## Test plan
- Reset/scan pattern (DIGITS=4, SCAN_DIV=8, BLANK_CYC=2): release rst → each an_n bit is low 6 cycles per 8-cycle slot, in order 1110,1101,1011,0111; frame_start period is 32 cycles.
- Update commit: upd_req with codes 3,7,0,9 (00110,10001,11000,10100) mid-frame → no change until the next frame, then upd_ack+frame_start pulse; digit 0 shows seg=1001111.
- Double request: two upd_req 5 cycles apart in one frame → single upd_ack; the second value is displayed.
- Request on commit cycle: upd_req coincident with the wrap → old pending committed, new value committed at the following frame with a second ack.
- Invalid/blank: digit 2=11100, digit 1=00000 → err=0100; digit 1 seg=0; digit 2 shows dash toggling every 64 frames with DISP_ERR_BLINK_EN, seg=0 without.
- Mid-frame reset: rst asserted during DRIVE of idx=2 → next edge an_n=1111, seg=0, pending dropped (no ack after release).
